spi_xfer_seq: RTL and testbench

- Word-level sequencer directly upstream of the SPI shift register.
- Buffers outgoing words in a TX FIFO and loads each into the shift register (latch, byte_sel, p_in).
- Fires go, waits for tip to rise and then fall, and captures the shift register's parallel output into an RX FIFO.
- Lets software or bus logic queue back-to-back SPI characters without polling tip.

---
 rtl/spi_xfer_pkg.sv | 16 +
 rtl/spi_sync_fifo.sv | 62 ++++++
 rtl/spi_xfer_seq.sv | 129 ++++++++++++
 tb/tb_spi_xfer_seq.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_pkg.sv
// rtl/spi_xfer_pkg.sv - shared state encoding and constants for the SPI word sequencer
package spi_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GO,
    ARM,
    RUN,
    CAPT
  } xfer_state_e;

  localparam logic [3:0] BYTE_SEL_ALL = 4'hF;
  localparam int         XFER_CNT_W   = 16;

endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - first-word fall-through circular FIFO with wrap-bit pointers
module spi_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level,
  output logic [DATA_W-1:0] head
);

  localparam int IDX_W = LVL_W - 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [LVL_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  // Equal index with differing wrap bits means the writer has lapped the reader.
  assign full    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign head    = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/spi_xfer_seq.sv
// rtl/spi_xfer_seq.sv - queues words into the SPI shift register and collects its results
module spi_xfer_seq
  import spi_xfer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_W-1:0]     tx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DATA_W-1:0]     rx_data,
  output logic                  sh_latch,
  output logic [3:0]            sh_byte_sel,
  output logic [DATA_W-1:0]     sh_p_in,
  output logic                  sh_go,
  input  logic                  sh_tip,
  input  logic [DATA_W-1:0]     sh_p_out,
  output logic                  busy,
  output logic [LVL_W-1:0]      tx_level,
  output logic [LVL_W-1:0]      rx_level,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  xfer_state_e           state_q, state_d;
  logic [DATA_W-1:0]     p_in_q, p_in_d;
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  logic              tx_full, tx_empty, tx_pop;
  logic              rx_full, rx_empty, rx_push;
  logic [DATA_W-1:0] tx_head;

  spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level),
    .head      (tx_head)
  );

  spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (sh_p_out),
    .pop       (rx_ready),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level),
    .head      (rx_data)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign busy     = (state_q != IDLE);
  assign xfer_cnt = xfer_cnt_q;

  always_comb begin
    state_d     = state_q;
    p_in_d      = p_in_q;
    xfer_cnt_d  = xfer_cnt_q;
    sh_latch    = 1'b0;
    sh_go       = 1'b0;
    sh_byte_sel = '0;
    sh_p_in     = '0;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    unique case (state_q)
      // Requiring RX space up front means CAPT can never overflow.
      IDLE: begin
        if (enable && !tx_empty && !rx_full && !sh_tip) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        sh_latch    = 1'b1;
        sh_byte_sel = BYTE_SEL_ALL;
        sh_p_in     = tx_head;
        p_in_d      = tx_head;
        tx_pop      = 1'b1;
        state_d     = GO;
      end
      GO: begin
        sh_go       = 1'b1;
        sh_byte_sel = BYTE_SEL_ALL;
        sh_p_in     = p_in_q;
        state_d     = ARM;
      end
      ARM: begin
        if (sh_tip) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!sh_tip) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        rx_push    = 1'b1;
        xfer_cnt_d = xfer_cnt_q + 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      p_in_q     <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      p_in_q     <= p_in_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb/tb_spi_xfer_seq.sv - self-checking bench for spi_xfer_seq with a behavioural shift-register model
module tb_spi_xfer_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] tx_data = '0;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [31:0] rx_data;
  logic        sh_latch;
  logic [3:0]  sh_byte_sel;
  logic [31:0] sh_p_in;
  logic        sh_go;
  logic        sh_tip = 1'b0;
  logic [31:0] sh_p_out = '0;
  logic        busy;
  logic [2:0]  tx_level;
  logic [2:0]  rx_level;
  logic [15:0] xfer_cnt;

  spi_xfer_seq dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .sh_latch    (sh_latch),
    .sh_byte_sel (sh_byte_sel),
    .sh_p_in     (sh_p_in),
    .sh_go       (sh_go),
    .sh_tip      (sh_tip),
    .sh_p_out    (sh_p_out),
    .busy        (busy),
    .tx_level    (tx_level),
    .rx_level    (rx_level),
    .xfer_cnt    (xfer_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Shift register model: result word is the loaded word with its nibbles reversed.
  function automatic logic [31:0] nibrev(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = w[4*(7-i) +: 4];
    return r;
  endfunction

  int          tip_dur = 10;
  int          tip_left = 0;
  bit          go_pend = 0;
  logic [31:0] sh_lat = '0;
  int          go_cnt = 0;
  logic [31:0] lat_log[$];
  logic [3:0]  bsel_log[$];
  logic [31:0] rx_log[$];
  logic [31:0] exp_lat[$];
  logic [31:0] exp_rx[$];
  logic [15:0] cnt_exp = '0;
  bit          rnd_rx = 0;

  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      go_pend  = 0;
      tip_left = 0;
      sh_tip   = 1'b0;
    end else begin
      if (go_pend) begin
        sh_tip   = 1'b1;
        tip_left = tip_dur;
        go_pend  = 0;
      end else if (tip_left > 0) begin
        tip_left--;
        if (tip_left == 0) begin
          sh_tip   = 1'b0;
          sh_p_out = nibrev(sh_lat);
        end
      end
      if (sh_latch) begin
        sh_lat = sh_p_in;
        lat_log.push_back(sh_p_in);
        bsel_log.push_back(sh_byte_sel);
      end
      if (sh_go) begin
        go_cnt++;
        go_pend = 1;
      end
      if (rx_valid && rx_ready) rx_log.push_back(rx_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    int n = 0;
    while (!tx_ready && n < 300) begin
      tx_valid = 1'b0;
      if (rnd_rx) rx_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("push_wait", 32'(n < 300), 1);
    tx_valid = 1'b1;
    tx_data  = w;
    step();
  endtask

  task automatic queue_word(input logic [31:0] w);
    exp_lat.push_back(w);
    exp_rx.push_back(nibrev(w));
    cnt_exp = cnt_exp + 16'd1;
    push_word(w);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rx_ready = 1'b1;
    while (!(xfer_cnt == cnt_exp && !busy && tx_level == 0 && !rx_valid) && n < 2000) begin
      step();
      n++;
    end
    chk(tag, 32'(n < 2000), 1);
    step();
    step();
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_lat_n"}, lat_log.size(), exp_lat.size());
    chk({tag, "_rx_n"}, rx_log.size(), exp_rx.size());
    while (lat_log.size() > 0 && exp_lat.size() > 0) begin
      chk({tag, "_lat"}, lat_log.pop_front(), exp_lat.pop_front());
      chk({tag, "_bsel"}, bsel_log.pop_front(), 4'hF);
    end
    while (rx_log.size() > 0 && exp_rx.size() > 0) begin
      chk({tag, "_rx"}, rx_log.pop_front(), exp_rx.pop_front());
    end
    chk({tag, "_cnt"}, xfer_cnt, cnt_exp);
    lat_log.delete(); bsel_log.delete(); rx_log.delete();
    exp_lat.delete(); exp_rx.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_valid = 1'b0;
    step();
    rst = 1'b0;
    cnt_exp = '0;
    lat_log.delete(); bsel_log.delete(); rx_log.delete();
    exp_lat.delete(); exp_rx.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int n;
    bit seen;
    logic [31:0] w;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_latch", sh_latch, 0);
    chk("rst_go", sh_go, 0);
    chk("rst_bsel", sh_byte_sel, 0);
    chk("rst_pin", sh_p_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txlvl", tx_level, 0);
    chk("rst_rxlvl", rx_level, 0);
    chk("rst_cnt", xfer_cnt, 0);
    chk("rst_rxvalid", rx_valid, 0);
    chk("rst_txready", tx_ready, 1);
    rst = 1'b0;
    step();

    // enable=0 holds the queued word
    push_word(32'hA5A5_0001);
    tx_valid = 1'b0;
    repeat (5) step();
    chk("dis_nolatch", lat_log.size(), 0);
    chk("dis_txlvl", tx_level, 1);
    chk("dis_txready", tx_ready, 1);
    chk("dis_busy", busy, 0);
    do_reset();
    chk("rst2_txlvl", tx_level, 0);

    // Single word with cycle-exact latency
    enable = 1'b1;
    rx_ready = 1'b0;
    tip_dur = 10;
    exp_lat.push_back(32'h1234_5678);
    exp_rx.push_back(32'h8765_4321);
    cnt_exp = 16'd1;
    push_word(32'h1234_5678);
    tx_valid = 1'b0;
    chk("one_nolatch_e0", sh_latch, 0);
    step();
    chk("one_latch", sh_latch, 1);
    chk("one_pin", sh_p_in, 32'h1234_5678);
    chk("one_bsel", sh_byte_sel, 4'hF);
    step();
    chk("one_go", sh_go, 1);
    chk("one_go_nolatch", sh_latch, 0);
    chk("one_go_pin", sh_p_in, 32'h1234_5678);
    n = 0;
    while (!rx_valid && n < 100) begin step(); n++; end
    chk("one_rx_wait", 32'(n < 100), 1);
    chk("one_rxdata", rx_data, 32'h8765_4321);
    chk("one_cnt", xfer_cnt, 1);
    chk("one_idle", busy, 0);
    drain("one_drain");
    check_logs("one");

    // Burst of DEPTH words, then overflow attempt
    enable = 1'b0;
    g0 = go_cnt;
    for (int i = 0; i < 4; i++) begin
      chk("burst_ready", tx_ready, 1);
      queue_word($urandom);
    end
    chk("burst_full", tx_ready, 0);
    chk("burst_lvl", tx_level, 4);
    tx_data = 32'hDEAD_BEEF;
    step();
    tx_valid = 1'b0;
    chk("burst_ovf_lvl", tx_level, 4);
    tip_dur = $urandom_range(1, 6);
    enable = 1'b1;
    drain("burst_drain");
    chk("burst_gos", go_cnt - g0, 4);
    check_logs("burst");

    // RX backpressure: FSM stalls with RX full
    rx_ready = 1'b0;
    g0 = go_cnt;
    for (int i = 0; i < 6; i++) queue_word($urandom);
    tx_valid = 1'b0;
    n = 0;
    while (!(rx_level == 4 && !busy) && n < 500) begin step(); n++; end
    chk("bp_wait", 32'(n < 500), 1);
    repeat (5) step();
    chk("bp_txlvl", tx_level, 2);
    chk("bp_busy", busy, 0);
    chk("bp_gos", go_cnt - g0, 4);
    chk("bp_head", rx_data, exp_rx[0]);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    seen = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (sh_latch) seen = 1;
    end
    chk("bp_restart", 32'(seen), 1);
    drain("bp_drain");
    check_logs("bp");

    // Randomised traffic with random consumer backpressure
    rnd_rx = 1;
    for (int i = 0; i < 12; i++) begin
      tip_dur = $urandom_range(1, 12);
      queue_word($urandom);
      tx_valid = 1'b0;
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        rx_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    rnd_rx = 0;
    drain("rnd_drain");
    check_logs("rnd");

    // enable dropped during RUN finishes the current word only
    enable = 1'b0;
    tip_dur = 8;
    g0 = go_cnt;
    queue_word(32'hCAFE_0001);
    queue_word(32'hCAFE_0002);
    tx_valid = 1'b0;
    enable = 1'b1;
    n = 0;
    while (!sh_tip && n < 50) begin step(); n++; end
    chk("en_tip_wait", 32'(n < 50), 1);
    enable = 1'b0;
    n = 0;
    while (busy && n < 50) begin step(); n++; end
    chk("en_idle_wait", 32'(n < 50), 1);
    repeat (10) step();
    chk("en_gos", go_cnt - g0, 1);
    chk("en_txlvl", tx_level, 1);
    chk("en_cnt", xfer_cnt, cnt_exp - 16'd1);
    chk("en_rx", rx_log.size(), 1);
    enable = 1'b1;
    drain("en_drain");
    check_logs("en");

    // Counter wrap
    force dut.xfer_cnt_q = 16'hFFFF;
    step();
    release dut.xfer_cnt_q;
    step();
    chk("wrap_pre", xfer_cnt, 16'hFFFF);
    cnt_exp = 16'hFFFF;
    w = $urandom;
    queue_word(w);
    tx_valid = 1'b0;
    drain("wrap_drain");
    chk("wrap_zero", xfer_cnt, 0);
    check_logs("wrap");

    // Reset during RUN discards the in-flight word
    tip_dur = 10;
    push_word(32'h0BAD_F00D);
    tx_valid = 1'b0;
    n = 0;
    while (!sh_tip && n < 50) begin step(); n++; end
    chk("rr_tip_wait", 32'(n < 50), 1);
    step();
    step();
    chk("rr_busy_pre", busy, 1);
    do_reset();
    g0 = go_cnt;
    chk("rr_txlvl", tx_level, 0);
    chk("rr_rxlvl", rx_level, 0);
    chk("rr_busy", busy, 0);
    chk("rr_cnt", xfer_cnt, 0);
    repeat (15) step();
    chk("rr_norx", rx_valid, 0);
    chk("rr_nogo", go_cnt - g0, 0);
    chk("rr_tip", sh_tip, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
